// File: rtl/counter_session_sched.sv
// Round-robin session scheduler in front of a shared bounded up/down counter.
// Each granted requester gets one session: load its target, ramp the counter
// up until it reports max, ramp it back down until it reports min, then pulse
// done. A step watchdog aborts sessions whose counter flags never arrive.
module counter_session_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   target,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     err,
    output logic                     busy,
    output logic                     load_en,
    output logic [WIDTH-1:0]         count_to,
    output logic                     count_inc,
    output logic                     count_dec,
    input  logic                     flag_count_max,
    input  logic                     flag_count_min
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned STEP_W = WIDTH + 1;

    // Watchdog limits: up phase may take 2^W-1 steps, whole session 2^(W+1)-1
    localparam logic [STEP_W-1:0] UP_LIMIT = STEP_W'((1 << WIDTH) - 1);
    localparam logic [STEP_W-1:0] DN_LIMIT = STEP_W'((1 << (WIDTH + 1)) - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_UP_PULSE,
        S_UP_WAIT,
        S_UP_CHECK,
        S_DN_PULSE,
        S_DN_WAIT,
        S_DN_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                abort_d;

    logic [WIDTH-1:0]    tgt_arr [N_REQ];
    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;

    function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Unpack the per-requester targets
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tgt_arr[i] = target[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first set req at or above the pointer, with wrap
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!arb_found && req[IDX_W'((int'(rr_q) + k) % N_REQ)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    // Next-state, winner/pointer latch and abort decision
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rr_d    = rr_q;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_LOAD;
                    win_d   = arb_idx;
                    rr_d    = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
                end
            end
            S_LOAD:     state_d = S_UP_WAIT;
            S_UP_PULSE: state_d = S_UP_WAIT;
            S_UP_WAIT:  state_d = S_UP_CHECK;
            S_UP_CHECK: begin
                if (flag_count_max) begin
                    state_d = S_DN_CHECK;
                end else if (step_q == UP_LIMIT) begin
                    state_d = S_DONE;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_UP_PULSE;
                end
            end
            S_DN_PULSE: state_d = S_DN_WAIT;
            S_DN_WAIT:  state_d = S_DN_CHECK;
            S_DN_CHECK: begin
                if (flag_count_min) begin
                    state_d = S_DONE;
                end else if (step_q == DN_LIMIT) begin
                    state_d = S_DONE;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_DN_PULSE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Step counter: one per issued pulse, cleared when the session ends
    always_comb begin
        step_d = step_q;
        if (state_q == S_UP_PULSE || state_q == S_DN_PULSE) begin
            step_d = step_q + STEP_W'(1);
        end else if (state_q == S_DONE) begin
            step_d = '0;
        end
    end

    // State, bookkeeping and Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            rr_q      <= '0;
            step_q    <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            load_en   <= 1'b0;
            count_to  <= '0;
            count_inc <= 1'b0;
            count_dec <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_q      <= rr_d;
            step_q    <= step_d;
            gnt       <= (state_d != S_IDLE) ? one_hot(win_d) : '0;
            done      <= (state_d == S_DONE) ? one_hot(win_d) : '0;
            err       <= abort_d;
            busy      <= (state_d != S_IDLE);
            load_en   <= (state_d == S_LOAD);
            count_to  <= (state_d == S_LOAD) ? tgt_arr[arb_idx] : '0;
            count_inc <= (state_d == S_UP_PULSE);
            count_dec <= (state_d == S_DN_PULSE);
        end
    end

endmodule

// File: tb/tb_counter_session_sched.sv
// Bench for counter_session_sched: a vector table of whole sessions plus a
// hand-written reset-in-session sequence, with a behavioural counter model.
module tb_counter_session_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] target = '0;
    logic [3:0]  gnt, done;
    logic        err, busy, load_en, count_inc, count_dec;
    logic [3:0]  count_to;
    logic        flag_count_max, flag_count_min;

    // Counter model: flags are registered from the counter value
    logic [3:0]  cval = '0;
    logic [3:0]  clim = '0;
    logic        fmax = 1'b0;
    logic        fmin = 1'b0;
    logic        stuck_max = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    counter_session_sched #(.N_REQ(4), .WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .target         (target),
        .gnt            (gnt),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .load_en        (load_en),
        .count_to       (count_to),
        .count_inc      (count_inc),
        .count_dec      (count_dec),
        .flag_count_max (flag_count_max),
        .flag_count_min (flag_count_min)
    );

    always #5 clk = ~clk;

    assign flag_count_max = fmax;
    assign flag_count_min = fmin;

    always @(posedge clk) begin
        if (load_en) begin
            cval <= 4'd0;
            clim <= count_to;
        end else if (count_inc) begin
            cval <= cval + 4'd1;
        end else if (count_dec) begin
            cval <= cval - 4'd1;
        end
        fmax <= stuck_max ? 1'b0 : (cval == clim);
        fmin <= (cval == 4'd0);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic        set_req;
        logic [3:0]  req;
        logic [15:0] tgt;
        logic        stuck;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_cnt_to;
        int          exp_len;
        int          exp_inc;
        int          exp_dec;
        logic        exp_err;
        int          mod_at;
        logic [3:0]  mod_clr;
        logic [15:0] mod_tgt;
    } vec_t;

    vec_t vecs [11];

    // Wait for a grant, follow the session to its done pulse, check it all
    task automatic run_session(input string nm, input vec_t v);
        int wait_cyc = 0;
        int len = 0;
        int n_inc = 0;
        int n_dec = 0;
        int last_inc = -1;
        int last_dec = -1;
        bit gnt_ok = 1'b1;
        bit excl_ok = 1'b1;
        bit gap_ok = 1'b1;
        logic [3:0] done_s;
        logic       err_s;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (gnt == 4'd0 && wait_cyc < 20);
        chk({nm, " grant latency"}, wait_cyc, 1);
        chk({nm, " grant"}, int'(gnt), int'(v.exp_gnt));
        if (gnt == 4'd0) return;
        chk({nm, " load_en"}, int'(load_en), 1);
        chk({nm, " count_to"}, int'(count_to), int'(v.exp_cnt_to));
        chk({nm, " busy"}, int'(busy), 1);
        forever begin
            len++;
            if (gnt != v.exp_gnt) gnt_ok = 1'b0;
            if (count_inc && count_dec) excl_ok = 1'b0;
            if (count_inc) begin
                if (last_inc >= 0 && len - last_inc != 3) gap_ok = 1'b0;
                last_inc = len;
                n_inc++;
            end
            if (count_dec) begin
                if (last_dec >= 0 && len - last_dec != 3) gap_ok = 1'b0;
                last_dec = len;
                n_dec++;
            end
            if (done != 4'd0 || len >= 200) break;
            if (len == v.mod_at) begin
                req    = req & ~v.mod_clr;
                target = v.mod_tgt;
            end
            @(negedge clk);
        end
        done_s = done;
        err_s  = err;
        chk({nm, " session length"}, len, v.exp_len);
        chk({nm, " inc pulses"}, n_inc, v.exp_inc);
        chk({nm, " dec pulses"}, n_dec, v.exp_dec);
        chk({nm, " pulse spacing ok"}, int'(gap_ok), 1);
        chk({nm, " inc/dec exclusive"}, int'(excl_ok), 1);
        chk({nm, " gnt steady"}, int'(gnt_ok), 1);
        chk({nm, " done"}, int'(done_s), int'(v.exp_gnt));
        chk({nm, " err"}, int'(err_s), int'(v.exp_err));
        req = req & ~done_s;
        @(negedge clk);
        chk({nm, " idle busy"}, int'(busy), 0);
        chk({nm, " idle gnt/done/err"}, int'({gnt, done, err}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: sim time limit reached");
        $fatal(1);
    end

    initial begin
        // set_req req tgt stuck exp_gnt cnt_to len inc dec err mod_at mod_clr mod_tgt
        vecs[0]  = '{1'b1, 4'b1111, 16'h1111, 1'b0, 4'b0001, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'b0000, 16'h1111, 1'b0, 4'b0010, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[2]  = '{1'b0, 4'b0000, 16'h1111, 1'b0, 4'b0100, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[3]  = '{1'b0, 4'b0000, 16'h1111, 1'b0, 4'b1000, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[4]  = '{1'b1, 4'b1001, 16'h1001, 1'b0, 4'b0001, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[5]  = '{1'b0, 4'b0000, 16'h1001, 1'b0, 4'b1000, 4'd1, 11, 1, 1, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[6]  = '{1'b1, 4'b0001, 16'h0003, 1'b0, 4'b0001, 4'd3, 23, 3, 3, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[7]  = '{1'b1, 4'b0010, 16'h0000, 1'b0, 4'b0010, 4'd0, 5, 0, 0, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[8]  = '{1'b1, 4'b0101, 16'h0200, 1'b1, 4'b0100, 4'd2, 49, 15, 0, 1'b1, 0, 4'b0000, 16'h0000};
        vecs[9]  = '{1'b0, 4'b0000, 16'h0200, 1'b0, 4'b0001, 4'd0, 5, 0, 0, 1'b0, 0, 4'b0000, 16'h0000};
        vecs[10] = '{1'b1, 4'b0001, 16'h000F, 1'b0, 4'b0001, 4'd15, 95, 15, 15, 1'b0, 10, 4'b0001, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset gnt", int'(gnt), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ctrl", int'({load_en, count_inc, count_dec, err, done}), 0);
        chk("reset count_to", int'(count_to), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle no req busy", int'(busy), 0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].set_req) begin
                req    = vecs[i].req;
                target = vecs[i].tgt;
            end
            stuck_max = vecs[i].stuck;
            run_session($sformatf("v%0d", i), vecs[i]);
        end
        stuck_max = 1'b0;

        // Reset in UP_WAIT of a target-4 session; rr pointer is 1 here
        req    = 4'b0011;
        target = 16'h0044;
        @(negedge clk);
        chk("rst seq grant", int'(gnt), 2);
        chk("rst seq load", int'(load_en), 1);
        @(negedge clk);
        chk("rst seq up_wait quiet", int'({load_en, count_inc, count_dec}), 0);
        chk("rst seq up_wait busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst seq gnt cleared", int'(gnt), 0);
        chk("rst seq busy cleared", int'(busy), 0);
        chk("rst seq no done/err", int'({done, err}), 0);
        chk("rst seq ctrl cleared", int'({load_en, count_inc, count_dec, count_to}), 0);
        reset = 1'b0;
        run_session("rst restart", '{1'b0, 4'b0000, 16'h0044, 1'b0, 4'b0001, 4'd4,
                                     29, 4, 4, 1'b0, 0, 4'b0000, 16'h0000});
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("final idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_session_sched.md
Name: counter_session_sched

Overview:
- Round-robin scheduler that shares one bounded up/down counter (4-bit, load_en/count_inc/count_dec in, registered flag_count_max/flag_count_min out) between N_REQ requesters.
- A granted requester gets one "session": load its target, ramp the counter up to the target, ramp it back down to zero, then receive a done pulse.
- The block sits between requester logic and the counter instance, and is the only driver of the counter's control inputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 4, counter/target width; must match the counter instance

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester session request; level, held until done
target  in  N_REQ*WIDTH  packed targets; requester i uses bits [i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot grant, high for the whole session
done  out  N_REQ  one-hot, 1-cycle pulse in the final session cycle
err  out  1  1-cycle pulse (with done) when the watchdog aborts a session
busy  out  1  high in every state except IDLE
load_en  out  1  to counter
count_to  out  WIDTH  to counter; latched target, valid while load_en=1
count_inc  out  1  to counter
count_dec  out  1  to counter
flag_count_max  in  1  from counter; reflects counter value two edges after the inc/load
flag_count_min  in  1  from counter; same timing as flag_count_max

Behaviour:
- Reset (synchronous): state=IDLE; gnt, done, err, busy, load_en, count_inc and count_dec all 0; count_to=0; rr pointer=0; step count=0. The counter is not reset by this block; the next LOAD reinitialises it.
- Outputs are Moore, decoded from registered state. count_inc and count_dec are never high together.
- Arbitration in IDLE only: pick the first req bit set, searching from the rr pointer upward with wrap. Latch the winner's index and target. The rr pointer becomes winner+1 (mod N_REQ) on grant.
- States and transitions:
  - IDLE: if any req is set -> LOAD; otherwise stay.
  - LOAD: load_en=1, count_to=latched target -> UP_WAIT.
  - UP_PULSE: count_inc=1, step++ -> UP_WAIT.
  - UP_WAIT: no outputs; flag pipeline settles -> UP_CHECK.
  - UP_CHECK: if flag_count_max -> DN_CHECK; else if step == 2^WIDTH-1 -> DONE with err; else -> UP_PULSE.
  - DN_PULSE: count_dec=1, step++ -> DN_WAIT.
  - DN_WAIT -> DN_CHECK.
  - DN_CHECK: if flag_count_min -> DONE; else if step == 2^(WIDTH+1)-1 -> DONE with err; else -> DN_PULSE.
  - DONE: done[winner]=1 (err=1 if aborted), step cleared -> IDLE.
- gnt[winner] is high from LOAD through DONE inclusive. busy = (state != IDLE).
- Latency for target T (no abort): 6T+5 cycles from LOAD to DONE inclusive. At least one IDLE cycle separates consecutive sessions.
- Target 0: UP_CHECK sees max immediately and DN_CHECK sees min immediately, giving a 5-cycle session.
- req or target changes after the grant are ignored; the session completes with the latched values. A req dropped while granted still receives its done pulse.
- Simultaneous max and min (target 0) is handled by the normal path; no special case.
- Reset mid-session: immediate return to IDLE; no done or err pulse for the aborted session.
- step is WIDTH+1 bits and never wraps; the watchdog bounds sessions when the counter flags misbehave.

Test Plan:
- req=0001, target0=3 -> gnt=0001 for 23 cycles; count_inc pulses 3 times, 3 cycles apart; count_dec pulses 3 times; done=0001 in cycle 23; err=0.
- req=0010, target1=0 -> load_en in cycle 1, no inc/dec pulses, done=0010 in cycle 5.
- req=1111, all targets=1 -> grants in order 0,1,2,3, each 11 cycles with 1 IDLE cycle between; then re-assert req=1001 -> next grant goes to 0 (pointer wrapped past 3).
- Model the counter with flag_count_max stuck at 0, target=2 -> 15 inc pulses, then done with err=1; gnt released.
- target0=15 -> 95-cycle session; during the ramp, flip target0 to 1 and drop req[0] -> still 15 up-pulses and 15 down-pulses, done=0001.
- Assert reset in UP_WAIT of a target=4 session -> next cycle all outputs 0 and busy=0; a held req then restarts with LOAD, arbitration from index 0.
